// File: rtl/beep_player.sv
// Command-driven buzzer tone player with a valid/ready request port and an active-low buzzer pin.
// Define BEEP_FIFO_EN to put a FIFO_DEPTH-entry command FIFO in front of the player FSM.
module beep_player #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DUR_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DIV_W-1:0] cmd_half_period,
    input  logic [DUR_W-1:0] cmd_dur_ms,
    input  logic             stop,
    output logic             buzzer,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CPM   = CLK_HZ / 1000;
    localparam int unsigned PRE_W = $clog2(CPM);

    typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [DIV_W-1:0]   half_q, half_d;
    logic [DIV_W-1:0]   hcnt_q, hcnt_d;
    logic               phase_q, phase_d;
    logic               buzzer_q, buzzer_d;
    // Holds cmd_ready low for one cycle after reset is released.
    logic               ready_en_q;

    logic               req_avail;
    logic [DIV_W-1:0]   req_half;
    logic [DUR_W-1:0]   req_dur;
    logic               load;

`ifdef BEEP_FIFO_EN
    localparam bit          ChainReq = 1'b1;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);

    logic [DIV_W-1:0] half_mem [FIFO_DEPTH];
    logic [DUR_W-1:0] dur_mem  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             push;

    // Depth is a power of two, so the count MSB alone marks full.
    assign full      = count_q[AW];
    assign cmd_ready = ready_en_q && !rst && !stop && !full;
    assign push      = cmd_valid && cmd_ready;
    assign req_avail = (count_q != '0);
    assign req_half  = half_mem[rd_ptr_q];
    assign req_dur   = dur_mem[rd_ptr_q];
    assign busy      = (state_q != StIdle) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(load);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            half_mem[wr_ptr_q] <= cmd_half_period;
            dur_mem[wr_ptr_q]  <= cmd_dur_ms;
        end
    end
`else
    localparam bit ChainReq = 1'b0;

    // Without storage the request is taken straight off the port while idle.
    assign cmd_ready = ready_en_q && !rst && !stop && (state_q == StIdle);
    assign req_avail = cmd_valid && cmd_ready;
    assign req_half  = cmd_half_period;
    assign req_dur   = cmd_dur_ms;
    assign busy      = (state_q != StIdle);
`endif

    assign load = req_avail && !stop &&
                  ((state_q == StIdle) || (ChainReq && (state_q == StDone)));

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        dur_d   = dur_q;
        half_d  = half_q;
        hcnt_d  = hcnt_q;
        phase_d = phase_q;

        unique case (state_q)
            StIdle: ;
            StPlay: begin
                if (pre_q == PRE_W'(CPM - 1)) begin
                    pre_d = '0;
                    dur_d = dur_q - 1'b1;
                    if (dur_q == DUR_W'(1)) begin
                        state_d = StDone;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                if (half_q != '0) begin
                    if (hcnt_q == half_q - 1'b1) begin
                        hcnt_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (load) begin
            half_d  = req_half;
            dur_d   = req_dur;
            pre_d   = '0;
            hcnt_d  = '0;
            phase_d = 1'b0;
            state_d = (req_dur == '0) ? StDone : StPlay;
        end

        if (stop) begin
            state_d = StIdle;
            pre_d   = '0;
            dur_d   = '0;
            hcnt_d  = '0;
            phase_d = 1'b0;
        end

        // Buzzer is registered from next-state values so the pin never glitches.
        buzzer_d = ((state_d == StPlay) && (half_d != '0)) ? phase_d : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pre_q      <= '0;
            dur_q      <= '0;
            half_q     <= '0;
            hcnt_q     <= '0;
            phase_q    <= 1'b0;
            buzzer_q   <= 1'b1;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            dur_q      <= dur_d;
            half_q     <= half_d;
            hcnt_q     <= hcnt_d;
            phase_q    <= phase_d;
            buzzer_q   <= buzzer_d;
            ready_en_q <= 1'b1;
        end
    end

    assign buzzer = buzzer_q;
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_beep_player.sv
// Directed self-checking bench for beep_player at CPM=4, DIV_W=8, DUR_W=8.
// Covers tone, rest, zero duration, stop, mid-tone reset and (with BEEP_FIFO_EN) FIFO chaining.
module tb_beep_player;

    localparam int unsigned CLK_HZ = 4000;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned DUR_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             stop = 1'b0;
    logic [DIV_W-1:0] cmd_half_period = '0;
    logic [DUR_W-1:0] cmd_dur_ms = '0;
    logic             cmd_ready;
    logic             buzzer;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beep_player #(
        .CLK_HZ    (CLK_HZ),
        .DIV_W     (DIV_W),
        .DUR_W     (DUR_W),
        .FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_half_period(cmd_half_period),
        .cmd_dur_ms     (cmd_dur_ms),
        .stop           (stop),
        .buzzer         (buzzer),
        .busy           (busy),
        .done           (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one request while ready; returns on the first PLAY (or DONE) cycle.
    task automatic send(input int h, input int d);
        cmd_half_period = DIV_W'(h);
        cmd_dur_ms      = DUR_W'(d);
        cmd_valid       = 1'b1;
        #1;
        chk("send_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
`ifdef BEEP_FIFO_EN
        tick();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_buzzer", 32'(buzzer), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        chk("ready_first_cycle", 32'(cmd_ready), 0);
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // Single tone: half=2, dur=3 -> 0,0,1,1 x3
        send(2, 3);
        for (int i = 0; i < 12; i++) begin
            chk("tone_buzzer", 32'(buzzer), ((i % 4) < 2) ? 0 : 1);
            chk("tone_busy", 32'(busy), 1);
            chk("tone_done", 32'(done), 0);
            tick();
        end
        chk("tone_done_pulse", 32'(done), 1);
        chk("tone_done_buzzer", 32'(buzzer), 1);
        tick();
        chk("tone_end_done", 32'(done), 0);
        chk("tone_end_busy", 32'(busy), 0);
        chk("tone_end_buzzer", 32'(buzzer), 1);
        chk("tone_end_ready", 32'(cmd_ready), 1);

        // Rest: half=0, dur=2 -> 8 silent PLAY cycles
        send(0, 2);
        for (int i = 0; i < 8; i++) begin
            chk("rest_buzzer", 32'(buzzer), 1);
            chk("rest_busy", 32'(busy), 1);
            chk("rest_done", 32'(done), 0);
            tick();
        end
        chk("rest_done_pulse", 32'(done), 1);
        chk("rest_done_busy", 32'(busy), 1);
        tick();
        chk("rest_end_busy", 32'(busy), 0);

        // Zero duration: straight to DONE
        send(5, 0);
        chk("zero_done", 32'(done), 1);
        chk("zero_buzzer", 32'(buzzer), 1);
        tick();
        chk("zero_end_done", 32'(done), 0);
        chk("zero_end_busy", 32'(busy), 0);

        // Abort: half=3, dur=10, stop on PLAY cycle 7 alongside a new request
        send(3, 10);
        for (int i = 0; i < 7; i++) begin
            chk("abort_buzzer", 32'(buzzer), (i / 3) % 2);
            tick();
        end
        stop            = 1'b1;
        cmd_valid       = 1'b1;
        cmd_half_period = 8'd1;
        cmd_dur_ms      = 8'd1;
        #1;
        chk("abort_ready_stop", 32'(cmd_ready), 0);
        chk("abort_buzzer_c7", 32'(buzzer), 0);
        tick();
        stop      = 1'b0;
        cmd_valid = 1'b0;
        chk("abort_buzzer_idle", 32'(buzzer), 1);
        chk("abort_busy", 32'(busy), 0);
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_done", 32'(done), 0);
            chk("abort_stay_idle", 32'(busy), 0);
            tick();
        end

        // Reset mid-tone: half=2, dur=5, rst on PLAY cycle 9
        send(2, 5);
        for (int i = 0; i < 9; i++) begin
            chk("rtone_buzzer", 32'(buzzer), ((i % 4) < 2) ? 0 : 1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rmid_buzzer", 32'(buzzer), 1);
        chk("rmid_busy", 32'(busy), 0);
        chk("rmid_ready", 32'(cmd_ready), 0);
        chk("rmid_done", 32'(done), 0);
        tick();
        chk("rmid_ready_back", 32'(cmd_ready), 1);
        send(1, 1);
        for (int i = 0; i < 4; i++) begin
            chk("rnew_buzzer", 32'(buzzer), i % 2);
            tick();
        end
        chk("rnew_done", 32'(done), 1);
        tick();
        chk("rnew_idle", 32'(busy), 0);

`ifdef BEEP_FIFO_EN
        // FIFO: six requests offered back-to-back, dur = 1..6
        begin
            int pushed   = 0;
            int n_done   = 0;
            int last     = 0;
            bit saw_full = 1'b0;
            for (int i = 0; i < 400 && n_done < 6; i++) begin
                if (pushed < 6) begin
                    cmd_valid       = 1'b1;
                    cmd_half_period = 8'd1;
                    cmd_dur_ms      = DUR_W'(pushed + 1);
                end else begin
                    cmd_valid = 1'b0;
                end
                #1;
                if (done) begin
                    n_done++;
                    if (n_done > 1) begin
                        chk("fifo_gap", i - last, n_done * 4 + 1);
                    end
                    last = i;
                end
                if (cmd_valid && !cmd_ready) saw_full = 1'b1;
                if (cmd_valid && cmd_ready) pushed++;
                tick();
            end
            cmd_valid = 1'b0;
            chk("fifo_full_seen", 32'(saw_full), 1);
            chk("fifo_pushed", pushed, 6);
            chk("fifo_dones", n_done, 6);
            tick();
            chk("fifo_idle", 32'(busy), 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
